// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: handshake state encoding, flag bundle, default width.
package alu_pkg;

    localparam int unsigned ALU_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_flags.sv
// Combinational C/Z/N/V derivation from an add/subtract result and its operand sign bits.
module alu_flags
    import alu_pkg::*;
#(
    parameter int unsigned N = ALU_W
) (
    input  logic [N-1:0] r,
    input  logic         co,
    input  logic         ctrl,
    input  logic         x_msb,
    input  logic         y_msb,
    output alu_flags_t   flags_c
);

    logic ye;

    // Carry becomes borrow when subtracting; V looks at the effective (inverted) y sign.
    always_comb begin
        ye        = y_msb ^ ctrl;
        flags_c   = '0;
        flags_c.c = co ^ ctrl;
        flags_c.z = (r == '0);
        flags_c.n = r[N-1];
        flags_c.v = (x_msb == ye) & (r[N-1] != x_msb);
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag capture, 2-entry skid buffer on a valid/ready interface,
// and a sticky overflow status bit.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned N = ALU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_r,
    input  logic         in_co,
    input  logic         in_ctrl,
    input  logic         in_x_msb,
    input  logic         in_y_msb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_r,
    output logic         out_c,
    output logic         out_z,
    output logic         out_n,
    output logic         out_v,
    output logic         sticky_v,
    input  logic         clr_sticky
);

    alu_state_t   state_q, state_nxt;
    logic [N-1:0] main_r_q, main_r_nxt;
    logic [N-1:0] skid_r_q, skid_r_nxt;
    alu_flags_t   main_f_q, main_f_nxt;
    alu_flags_t   skid_f_q, skid_f_nxt;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         sticky_q, sticky_nxt;
    alu_flags_t   flags_c;
    logic         accept_c;
    logic         xfer_c;

    alu_flags #(.N(N)) u_flags (
        .r       (in_r),
        .co      (in_co),
        .ctrl    (in_ctrl),
        .x_msb   (in_x_msb),
        .y_msb   (in_y_msb),
        .flags_c (flags_c)
    );

    // State, entry storage and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_r_q    <= '0;
            main_f_q    <= '0;
            skid_r_q    <= '0;
            skid_f_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            main_r_q    <= main_r_nxt;
            main_f_q    <= main_f_nxt;
            skid_r_q    <= skid_r_nxt;
            skid_f_q    <= skid_f_nxt;
            in_ready_q  <= (state_nxt != ST_TWO);
            out_valid_q <= (state_nxt != ST_EMPTY);
            sticky_q    <= sticky_nxt;
        end
    end

    // Next-state and entry movement; main register only changes when it is free or draining.
    always_comb begin
        accept_c   = in_valid & in_ready_q;
        xfer_c     = out_valid_q & out_ready;
        state_nxt  = state_q;
        main_r_nxt = main_r_q;
        main_f_nxt = main_f_q;
        skid_r_nxt = skid_r_q;
        skid_f_nxt = skid_f_q;
        sticky_nxt = (sticky_q & ~clr_sticky) | (accept_c & flags_c.v);

        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    main_r_nxt = in_r;
                    main_f_nxt = flags_c;
                    state_nxt  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c && xfer_c) begin
                    main_r_nxt = in_r;
                    main_f_nxt = flags_c;
                end else if (accept_c) begin
                    skid_r_nxt = in_r;
                    skid_f_nxt = flags_c;
                    state_nxt  = ST_TWO;
                end else if (xfer_c) begin
                    state_nxt  = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer_c) begin
                    main_r_nxt = skid_r_q;
                    main_f_nxt = skid_f_q;
                    state_nxt  = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = main_r_q;
    assign out_c     = main_f_q.c;
    assign out_z     = main_f_q.z;
    assign out_n     = main_f_q.n;
    assign out_v     = main_f_q.v;
    assign sticky_v  = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and randomized checks of alu_result_stage flags, skid buffering and reset.
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r;
    logic       in_co;
    logic       in_ctrl;
    logic       in_x_msb;
    logic       in_y_msb;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_r;
    logic       out_c;
    logic       out_z;
    logic       out_n;
    logic       out_v;
    logic       sticky_v;
    logic       clr_sticky;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    alu_result_stage #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_r       (in_r),
        .in_co      (in_co),
        .in_ctrl    (in_ctrl),
        .in_x_msb   (in_x_msb),
        .in_y_msb   (in_y_msb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_c      (out_c),
        .out_z      (out_z),
        .out_n      (out_n),
        .out_v      (out_v),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic co, input logic ctrl,
                         input logic xm, input logic ym);
        in_r     = r;
        in_co    = co;
        in_ctrl  = ctrl;
        in_x_msb = xm;
        in_y_msb = ym;
    endtask

    // One accepted beat; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] r, input logic co, input logic ctrl,
                        input logic xm, input logic ym);
        @(negedge clk);
        drive(r, co, ctrl, xm, ym);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [3:0] cur_flags();
        return {out_c, out_z, out_n, out_v};
    endfunction

    initial begin
        logic [7:0] x, y, yy, r;
        logic [8:0] s9;
        logic       ctrl;
        logic [3:0] ef;
        int         sfull;
        logic [11:0] front;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_r", 32'(out_r), 32'h00);
        check("rst_flags", 32'(cur_flags()), 32'h0);
        check("rst_sticky", 32'(sticky_v), 32'd0);

        // 5-3
        send(8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
        check("sub53_valid", 32'(out_valid), 32'd1);
        check("sub53_r", 32'(out_r), 32'h02);
        check("sub53_czn_v", 32'(cur_flags()), 32'b0000);
        // 3-5: borrow and negative
        send(8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sub35_r", 32'(out_r), 32'hFE);
        check("sub35_czn_v", 32'(cur_flags()), 32'b1010);
        check("sub35_sticky", 32'(sticky_v), 32'd0);
        // 0x7F+0x01: signed overflow
        send(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        check("addov_r", 32'(out_r), 32'h80);
        check("addov_czn_v", 32'(cur_flags()), 32'b0011);
        check("addov_sticky", 32'(sticky_v), 32'd1);
        // Clear coincident with a V=1 accept: set wins
        @(negedge clk);
        drive(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clr_sticky = 1'b0;
        check("sticky_setwins", 32'(sticky_v), 32'd1);
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        check("sticky_clear", 32'(sticky_v), 32'd0);
        // 0x80-0x80: zero
        send(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        check("subz_r", 32'(out_r), 32'h00);
        check("subz_czn_v", 32'(cur_flags()), 32'b0100);

        // Backpressure: A and B back-to-back into a stalled output
        repeat (2) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_drained", 32'(out_valid), 32'd0);
        send(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_a_ready", 32'(in_ready), 32'd1);
        check("bp_a_r", 32'(out_r), 32'h11);
        send(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_two_ready", 32'(in_ready), 32'd0);
        check("bp_two_valid", 32'(out_valid), 32'd1);
        check("bp_two_r", 32'(out_r), 32'h11);
        @(negedge clk);
        drive(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hold_r", 32'(out_r), 32'h11);
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_b_r", 32'(out_r), 32'h22);
        check("bp_b_ready", 32'(in_ready), 32'd1);
        check("bp_b_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("bp_empty", 32'(out_valid), 32'd0);

        // Random traffic against an arithmetic reference model
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected", 32'(out_r), 32'hFFFF);
                end else begin
                    front = exp_q.pop_front();
                    check("rnd_entry", 32'({out_r, cur_flags()}), 32'(front));
                end
            end
            x    = 8'($urandom);
            y    = 8'($urandom);
            ctrl = 1'($urandom_range(0, 1));
            yy   = ctrl ? ~y : y;
            s9   = {1'b0, x} + {1'b0, yy} + 9'(ctrl);
            r    = s9[7:0];
            drive(r, s9[8], ctrl, x[7], y[7]);
            in_valid = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                sfull = ctrl ? (int'($signed(x)) - int'($signed(y)))
                             : (int'($signed(x)) + int'($signed(y)));
                ef[3] = ctrl ? (x < y) : s9[8];
                ef[2] = (r == 8'h00);
                ef[1] = r[7];
                ef[0] = (sfull > 127) || (sfull < -128);
                exp_q.push_back({r, ef});
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            if (out_valid) begin
                front = exp_q.pop_front();
                check("drain_entry", 32'({out_r, cur_flags()}), 32'(front));
            end
            @(negedge clk);
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while holding two entries
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        send(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_ready", 32'(in_ready), 32'd0);
        check("pre_rst_sticky", 32'(sticky_v), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_sticky", 32'(sticky_v), 32'd0);
        check("arst_out_r", 32'(out_r), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
